dmem_arbiter: RTL and testbench

//  Two-requester round-robin arbiter sharing one single-port data memory.

---
 rtl/dmem_arbiter.sv | 96 +++++++++
 tb/tb_dmem_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter letting the CPU path (req 0) and the debug/DMA loader (req 1)
// share one single-port data memory through a two-stage access/response pipeline.
module dmem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_rsp_valid,
  output logic [DATA_WIDTH-1:0] r0_rsp_rdata,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_rsp_valid,
  output logic [DATA_WIDTH-1:0] r1_rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  logic                  r_last_gnt;
  logic                  r_s1_vld;
  logic                  r_s1_we;
  logic                  r_s1_owner;
  logic [ADDR_WIDTH-1:0] r_s1_addr;
  logic [DATA_WIDTH-1:0] r_s1_wdata;
  logic                  r_s2_vld;
  logic                  r_s2_owner;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;

  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_rsp_data;

  // Under contention the requester that did not win last time gets the grant.
  always_comb begin
    w_gnt0   = 1'b0;
    w_gnt1   = 1'b0;
    w_gnt0   = ~rst & r0_valid & (~r1_valid | r_last_gnt);
    w_gnt1   = ~rst & r1_valid & (~r0_valid | ~r_last_gnt);
    w_accept = w_gnt0 | w_gnt1;
  end

  assign r0_ready = w_gnt0;
  assign r1_ready = w_gnt1;

  // Writes report zero data; reads capture the combinational memory output.
  assign w_rsp_data = r_s1_we ? '0 : mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_gnt <= 1'b1;
      r_s1_vld   <= 1'b0;
      r_s1_we    <= 1'b0;
      r_s1_owner <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_wdata <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_owner <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_last_gnt <= w_gnt1;
        r_s1_owner <= w_gnt1;
        r_s1_we    <= w_gnt1 ? r1_we    : r0_we;
        r_s1_addr  <= w_gnt1 ? r1_addr  : r0_addr;
        r_s1_wdata <= w_gnt1 ? r1_wdata : r0_wdata;
      end
      r_s2_vld   <= r_s1_vld;
      r_s2_owner <= r_s1_owner;
      if (r_s1_vld && !r_s1_owner) r_rdata0 <= w_rsp_data;
      if (r_s1_vld &&  r_s1_owner) r_rdata1 <= w_rsp_data;
    end
  end

  assign mem_addr     = r_s1_addr;
  assign mem_wdata    = r_s1_wdata;
  assign mem_we       = r_s1_vld & r_s1_we;
  assign r0_rsp_valid = r_s2_vld & ~r_s2_owner;
  assign r1_rsp_valid = r_s2_vld &  r_s2_owner;
  assign r0_rsp_rdata = r_rdata0;
  assign r1_rsp_rdata = r_rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed requests push expected responses,
// a negedge monitor pops and checks data and arrival cycle.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        r0_valid = 1'b0, r0_we = 1'b0, r0_ready, r0_rsp_valid;
  logic [31:0] r0_addr = '0, r0_wdata = '0, r0_rsp_rdata;
  logic        r1_valid = 1'b0, r1_we = 1'b0, r1_ready, r1_rsp_valid;
  logic [31:0] r1_addr = '0, r1_wdata = '0, r1_rsp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  typedef struct {
    logic [31:0] d;
    int unsigned c;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;

  logic [31:0] mem [32];
  bit          mem_loaded = 1'b0;

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_rdata(r0_rsp_rdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_rdata(r1_rsp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // 128-byte word memory: address bits above 6 are ignored, so 0x80 aliases 0x00.
  assign mem_rdata = mem[mem_addr[6:2]];
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA000_0000 | 32'(i);
      mem_loaded <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr[6:2]] <= mem_wdata;
    end
  end

  // Response monitor: every pulse must match the oldest expectation of its owner.
  always @(negedge clk) begin
    if (r0_rsp_valid) begin
      n_vec++;
      if (q0.size() == 0) begin
        n_bad++;
        $display("FAIL r0_stray_rsp cyc=%0d rdata=%h required no response", cyc, r0_rsp_rdata);
      end else begin
        exp_t e;
        e = q0.pop_front();
        if (r0_rsp_rdata !== e.d || cyc != e.c) begin
          n_bad++;
          $display("FAIL r0_rsp got data=%h cyc=%0d required data=%h cyc=%0d",
                   r0_rsp_rdata, cyc, e.d, e.c);
        end
      end
    end
    if (r1_rsp_valid) begin
      n_vec++;
      if (q1.size() == 0) begin
        n_bad++;
        $display("FAIL r1_stray_rsp cyc=%0d rdata=%h required no response", cyc, r1_rsp_rdata);
      end else begin
        exp_t e;
        e = q1.pop_front();
        if (r1_rsp_rdata !== e.d || cyc != e.c) begin
          n_bad++;
          $display("FAIL r1_rsp got data=%h cyc=%0d required data=%h cyc=%0d",
                   r1_rsp_rdata, cyc, e.d, e.c);
        end
      end
    end
  end

  // One request cycle: present both channels, check grants, queue expected responses.
  task automatic drive(input logic v0, input logic we0, input logic [31:0] a0,
                       input logic [31:0] d0, input logic [31:0] e0,
                       input logic v1, input logic we1, input logic [31:0] a1,
                       input logic [31:0] d1, input logic [31:0] e1,
                       input logic x0, input logic x1);
    exp_t e;
    @(negedge clk);
    r0_valid = v0; r0_we = we0; r0_addr = a0; r0_wdata = d0;
    r1_valid = v1; r1_we = we1; r1_addr = a1; r1_wdata = d1;
    #1;
    n_vec++;
    if (r0_ready !== x0 || r1_ready !== x1) begin
      n_bad++;
      $display("FAIL grant cyc=%0d got rdy0=%b rdy1=%b required rdy0=%b rdy1=%b",
               cyc, r0_ready, r1_ready, x0, x1);
    end
    if (x0) begin e.d = e0; e.c = cyc + 2; q0.push_back(e); end
    if (x1) begin e.d = e1; e.c = cyc + 2; q1.push_back(e); end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      r0_valid = 1'b0;
      r1_valid = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    n_vec++;
    if (r0_ready !== 1'b0 || r1_ready !== 1'b0 || r0_rsp_valid !== 1'b0 ||
        r1_rsp_valid !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 ||
        mem_wdata !== 32'h0 || r0_rsp_rdata !== 32'h0 || r1_rsp_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL %s got rdy=%b%b rsp=%b%b we=%b addr=%h wd=%h rd0=%h rd1=%h required all 0",
               tag, r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, mem_we,
               mem_addr, mem_wdata, r0_rsp_rdata, r1_rsp_rdata);
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #2 check_zero("reset_initial");
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;

    // Write then immediately read the same address.
    drive(1, 1, 32'h10, 32'hDEADBEEF, 32'h0,        0, 0, 32'h0, 32'h0, 32'h0, 1, 0);
    drive(1, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 0, 32'h0, 32'h0, 32'h0, 1, 0);

    // Write at 0x80 lands on the word at 0x00.
    drive(0, 0, 32'h0, 32'h0, 32'h0, 1, 1, 32'h80, 32'hA5, 32'h0,  0, 1);
    drive(0, 0, 32'h0, 32'h0, 32'h0, 1, 0, 32'h00, 32'h0,  32'hA5, 0, 1);

    // Requester 1 alone streams five reads.
    drive(0, 0, 32'h0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0, 32'hA000_0008, 0, 1);
    drive(0, 0, 32'h0, 32'h0, 32'h0, 1, 0, 32'h24, 32'h0, 32'hA000_0009, 0, 1);
    drive(0, 0, 32'h0, 32'h0, 32'h0, 1, 0, 32'h28, 32'h0, 32'hA000_000A, 0, 1);
    drive(0, 0, 32'h0, 32'h0, 32'h0, 1, 0, 32'h2C, 32'h0, 32'hA000_000B, 0, 1);
    drive(0, 0, 32'h0, 32'h0, 32'h0, 1, 0, 32'h30, 32'h0, 32'hA000_000C, 0, 1);

    // Both contend for eight cycles; losers hold their request until granted.
    drive(1, 0, 32'h40, 32'h0, 32'hA000_0010, 1, 0, 32'h60, 32'h0, 32'hA000_0018, 1, 0);
    drive(1, 0, 32'h44, 32'h0, 32'hA000_0011, 1, 0, 32'h60, 32'h0, 32'hA000_0018, 0, 1);
    drive(1, 0, 32'h44, 32'h0, 32'hA000_0011, 1, 0, 32'h64, 32'h0, 32'hA000_0019, 1, 0);
    drive(1, 0, 32'h48, 32'h0, 32'hA000_0012, 1, 0, 32'h64, 32'h0, 32'hA000_0019, 0, 1);
    drive(1, 0, 32'h48, 32'h0, 32'hA000_0012, 1, 0, 32'h68, 32'h0, 32'hA000_001A, 1, 0);
    drive(1, 0, 32'h4C, 32'h0, 32'hA000_0013, 1, 0, 32'h68, 32'h0, 32'hA000_001A, 0, 1);
    drive(1, 0, 32'h4C, 32'h0, 32'hA000_0013, 1, 0, 32'h6C, 32'h0, 32'hA000_001B, 1, 0);
    drive(0, 0, 32'h0,  32'h0, 32'h0,         1, 0, 32'h6C, 32'h0, 32'hA000_001B, 0, 1);

    // Reset lands while a read response is out and a write sits in stage 1.
    drive(1, 0, 32'h10, 32'h0,  32'hDEADBEEF, 0, 0, 32'h0,  32'h0,  32'h0, 1, 0);
    drive(0, 0, 32'h0,  32'h0,  32'h0,        1, 1, 32'h04, 32'h55, 32'h0, 0, 1);
    @(posedge clk);
    #2;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    rst = 1'b1;
    q0.delete();
    q1.delete();
    #1 check_zero("reset_midrun");
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;

    // First contended grant after reset goes to requester 0; the dropped write left 0x04 intact.
    drive(1, 0, 32'h44, 32'h0, 32'hA000_0011, 1, 0, 32'h04, 32'h0, 32'hA000_0001, 1, 0);
    drive(0, 0, 32'h0,  32'h0, 32'h0,         1, 0, 32'h04, 32'h0, 32'hA000_0001, 0, 1);
    idle(5);

    n_vec++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_bad++;
      $display("FAIL drain got pending r0=%0d r1=%0d required 0 0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout at cyc=%0d required completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
